// File: rtl/set_serial.sv
// rtl/set_serial.sv - nibble-serial unsigned compare/subtract unit with valid/ready handshakes
//
// Computes diff = a - b one 4-bit slice per clock (a + ~b + carry ripple),
// then derives a set-on-compare result from the final carry and zero flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operation handshake (accepted only in IDLE)
//   op                  compare code: SEQ SNE SLT SGT SLE SGE, 110/111 -> 0
//   a, b                unsigned operands, bit 0 = least significant
//   out_valid, out_ready result handshake (result held in DONE)
//   set                 compare result
//   diff                a - b modulo 2^width, bit 0 = least significant
//   busy                high while slices are being processed
module set_serial #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [0:width-1] a,
    input  logic [0:width-1] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             set,
    output logic [0:width-1] diff,
    output logic             busy
);

    localparam int nslices = width / 4;
    localparam int cw      = (nslices > 1) ? $clog2(nslices) : 1;
    localparam int iw      = (width > 1) ? $clog2(width) : 1;
    localparam logic [cw-1:0] last_slice = cw'(nslices - 1);

    typedef enum logic [1:0] {
        st_idle,
        st_busy,
        st_done
    } state_t;

    state_t state, state_nxt;

    logic [0:width-1] a_r, b_r, diff_r, diff_nxt;
    logic [2:0]       op_r;
    logic [cw-1:0]    cnt;
    logic             carry, zero, set_r;
    logic             carry_nxt, zero_nxt, set_nxt;
    logic [iw-1:0]    base;
    logic [3:0]       sa, sb;
    logic [4:0]       sum;

    // Operands use ascending bit order with bit 0 as the LSB, so a slice is
    // gathered bit by bit; a part-select would reverse its significance.
    always_comb begin
        sa       = '0;
        sb       = '0;
        diff_nxt = diff_r;
        base     = iw'({cnt, 2'b00});
        for (int j = 0; j < 4; j++) begin
            sa[j] = a_r[base + iw'(j)];
            sb[j] = b_r[base + iw'(j)];
        end
        sum = {1'b0, sa} + {1'b0, ~sb} + {4'b0000, carry};
        for (int j = 0; j < 4; j++) begin
            diff_nxt[base + iw'(j)] = sum[j];
        end
        carry_nxt = sum[4];
        zero_nxt  = zero & (sum[3:0] == 4'b0000);
    end

    // Carry out of a + ~b + 1 is the unsigned "a >= b" flag.
    always_comb begin
        set_nxt = 1'b0;
        case (op_r)
            3'b000:  set_nxt = zero_nxt;
            3'b001:  set_nxt = ~zero_nxt;
            3'b010:  set_nxt = ~carry_nxt;
            3'b011:  set_nxt = carry_nxt & ~zero_nxt;
            3'b100:  set_nxt = ~carry_nxt | zero_nxt;
            3'b101:  set_nxt = carry_nxt;
            default: set_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: if (in_valid) state_nxt = st_busy;
            st_busy: if (cnt == last_slice) state_nxt = st_done;
            st_done: if (out_ready) state_nxt = st_idle;
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            carry  <= 1'b1;
            zero   <= 1'b1;
            set_r  <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        op_r   <= op;
                        diff_r <= '0;
                        cnt    <= '0;
                        carry  <= 1'b1;
                        zero   <= 1'b1;
                    end
                end
                st_busy: begin
                    diff_r <= diff_nxt;
                    carry  <= carry_nxt;
                    zero   <= zero_nxt;
                    cnt    <= cnt + cw'(1);
                    if (cnt == last_slice) set_r <= set_nxt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == st_idle);
    assign out_valid = (state == st_done);
    assign busy      = (state == st_busy);
    assign set       = set_r;
    assign diff      = diff_r;

endmodule
